// File: rtl/scoreboard_hazard_unit_if.sv
// Hazard-unit bundle between the ID stage and the scoreboard.
//   master : the ID stage. Drives the decoded instruction fields and flush,
//            receives the stall/enable controls.
//   slave  : the scoreboard hazard unit.
// Signals
//   id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_reg_write,
//   id_is_load, id_is_store, id_is_mc, flush      (master -> slave)
//   pc_write, if_id_write, control_stall, mc_busy, stall_cycles (slave -> master)
interface scoreboard_hazard_unit_if #(
  parameter int REG_AW  = 5,
  parameter int STALL_W = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_is_load;
  logic              id_is_store;
  logic              id_is_mc;
  logic              flush;

  logic               pc_write;
  logic               if_id_write;
  logic               control_stall;
  logic               mc_busy;
  logic [STALL_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_is_load, id_is_store, id_is_mc, flush,
    input  pc_write, if_id_write, control_stall, mc_busy, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_is_load, id_is_store, id_is_mc, flush,
    output pc_write, if_id_write, control_stall, mc_busy, stall_cycles
  );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// Per-register countdown scoreboard sitting beside ID.
// Stalls PC / IF_ID and bubbles ID_EX on:
//   - RAW against a pending load or multi-cycle (MUL/DIV) result,
//   - WAW against an in-flight write that would land later than this one,
//   - a busy multi-cycle unit.
// Each issued producer's counter ages one per clock; zero means the result is
// forwardable at the EX input.
// Ports
//   clk, rst : pipeline clock, synchronous active-high reset
//   hz       : slave side of scoreboard_hazard_unit_if (decoded ID fields in,
//              pc_write / if_id_write / control_stall / mc_busy / stall_cycles out)
module scoreboard_hazard_unit #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int LD_LAT   = 1,
  parameter int MC_LAT   = 4,
  parameter int STALL_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  scoreboard_hazard_unit_if.slave hz
);

  localparam int CW = $clog2(MC_LAT + 1);
  localparam logic [CW-1:0] LD_LAT_C = CW'(LD_LAT);
  localparam logic [CW-1:0] MC_LAT_C = CW'(MC_LAT);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  logic [CW-1:0]       cnt [NUM_REGS];
  logic [NUM_REGS-1:0] ld;
  logic [CW-1:0]       mc_cnt;
  logic [STALL_W-1:0]  stall_cycles;

  logic          raw1;
  logic          raw2;
  logic          waw;
  logic          struct_hz;
  logic          stall;
  logic          issue;
  logic [CW-1:0] newlat;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    newlat = hz.id_is_mc ? MC_LAT_C : (hz.id_is_load ? LD_LAT_C : '0);

    raw1 = hz.id_uses_rs1 && (hz.id_rs1 != '0) && (cnt[hz.id_rs1] != '0);

    // A store whose data comes from a load in its final bubble cycle picks
    // the value up through MEM->MEM forwarding, so it need not wait.
    raw2 = hz.id_uses_rs2 && (hz.id_rs2 != '0) && (cnt[hz.id_rs2] != '0) &&
           !(hz.id_is_store && ld[hz.id_rs2] && (cnt[hz.id_rs2] == ONE_C));

    // Only an older write landing after ours is a problem; x0 is never pending.
    waw = hz.id_reg_write && (hz.id_rd != '0) && (cnt[hz.id_rd] > newlat);

    struct_hz = hz.id_is_mc && (mc_cnt != '0);

    // Flush squashes the slot, so it never stalls and never issues.
    stall = hz.id_valid && !hz.flush && (raw1 || raw2 || waw || struct_hz);
    issue = hz.id_valid && !hz.flush && !stall;
  end

  always_comb begin
    hz.pc_write      = !rst && !stall;
    hz.if_id_write   = !rst && !stall;
    hz.control_stall = rst || stall;
    hz.mc_busy       = !rst && (mc_cnt != '0);
    hz.stall_cycles  = stall_cycles;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt[i] <= '0;
      end
      ld           <= '0;
      mc_cnt       <= '0;
      stall_cycles <= '0;
    end else begin
      // Already-issued producers keep ageing even when ID is flushed.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - ONE_C;
          if (cnt[i] == ONE_C) begin
            ld[i] <= 1'b0;
          end
        end
      end

      // Later assignment wins over the decrement of the same entry.
      if (issue && hz.id_reg_write && (hz.id_rd != '0)) begin
        cnt[hz.id_rd] <= newlat;
        ld[hz.id_rd]  <= hz.id_is_load;
      end

      if (issue && hz.id_is_mc) begin
        mc_cnt <= MC_LAT_C;
      end else if (mc_cnt != '0) begin
        mc_cnt <= mc_cnt - ONE_C;
      end

      if (stall) begin
        stall_cycles <= sat_inc(stall_cycles);
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
module tb_scoreboard_hazard_unit;

  localparam int LD_LAT    = 1;
  localparam int MC_LAT    = 4;
  localparam int STALL_MAX = 65535;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  scoreboard_hazard_unit_if #(.REG_AW(5), .STALL_W(16)) hz ();

  scoreboard_hazard_unit #(
    .NUM_REGS(32),
    .REG_AW  (5),
    .LD_LAT  (LD_LAT),
    .MC_LAT  (MC_LAT),
    .STALL_W (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz.slave)
  );

  // Reference model: each register remembers the cycle at which its result
  // becomes forwardable; the multi-cycle unit remembers when it frees up.
  int c;
  int avail [32];
  bit isld  [32];
  int mc_avail;
  int m_stalls;
  bit m_known;

  int errors;
  int checks;

  function automatic int rem(input int r);
    if (r == 0) return 0;
    return (avail[r] > c) ? avail[r] - c : 0;
  endfunction

  function automatic int lat_of(input bit is_mc, input bit is_ld);
    return is_mc ? MC_LAT : (is_ld ? LD_LAT : 0);
  endfunction

  function automatic bit m_stall();
    int  nl;
    bit  r1, r2, w, s;
    if (!hz.id_valid || hz.flush) return 1'b0;
    nl = lat_of(hz.id_is_mc, hz.id_is_load);
    r1 = hz.id_uses_rs1 && (rem(int'(hz.id_rs1)) > 0);
    r2 = hz.id_uses_rs2 && (rem(int'(hz.id_rs2)) > 0) &&
         !(hz.id_is_store && isld[hz.id_rs2] && (rem(int'(hz.id_rs2)) == 1));
    w  = hz.id_reg_write && (rem(int'(hz.id_rd)) > nl);
    s  = hz.id_is_mc && (mc_avail > c);
    return r1 | r2 | w | s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, c);
    end
  endtask

  task automatic check_outputs();
    bit es;
    es = !rst && m_stall();
    chk("pc_write",      32'(hz.pc_write),      32'(!rst && !es));
    chk("if_id_write",   32'(hz.if_id_write),   32'(!rst && !es));
    chk("control_stall", 32'(hz.control_stall), 32'(rst || es));
    chk("mc_busy",       32'(hz.mc_busy),       32'(!rst && (mc_avail > c)));
    if (m_known) chk("stall_cycles", 32'(hz.stall_cycles), 32'(m_stalls));
  endtask

  task automatic model_update();
    int nl;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        avail[i] = 0;
        isld[i]  = 1'b0;
      end
      mc_avail = 0;
      m_stalls = 0;
      m_known  = 1'b1;
    end else if (m_stall()) begin
      if (m_stalls < STALL_MAX) m_stalls++;
    end else if (hz.id_valid && !hz.flush) begin
      nl = lat_of(hz.id_is_mc, hz.id_is_load);
      if (hz.id_reg_write && (hz.id_rd != 5'd0)) begin
        avail[hz.id_rd] = c + 1 + nl;
        isld[hz.id_rd]  = hz.id_is_load;
      end
      if (hz.id_is_mc) mc_avail = c + 1 + MC_LAT;
    end
    c++;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step(output bit stalled, output bit busy);
    @(negedge clk);
    check_outputs();
    stalled = hz.control_stall;
    busy    = hz.mc_busy;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit rw, input bit ld, input bit st, input bit mc,
                       input bit fl);
    hz.id_valid     = v;
    hz.id_rs1       = 5'(rs1);
    hz.id_uses_rs1  = u1;
    hz.id_rs2       = 5'(rs2);
    hz.id_uses_rs2  = u2;
    hz.id_rd        = 5'(rd);
    hz.id_reg_write = rw;
    hz.id_is_load   = ld;
    hz.id_is_store  = st;
    hz.id_is_mc     = mc;
    hz.flush        = fl;
  endtask

  task automatic idle(input int n);
    bit s, b;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step(s, b);
  endtask

  // Steps the currently driven instruction until it issues; counts stall
  // cycles and mc_busy cycles seen on the way (including the issue cycle).
  task automatic run_until_issue(input string name, output int nstall, output int nbusy);
    bit s, b;
    nstall = 0;
    nbusy  = 0;
    for (int i = 0; i < 40; i++) begin
      step(s, b);
      if (b) nbusy++;
      if (!s) return;
      nstall++;
    end
    errors++;
    checks++;
    $display("FAIL %s: instruction never issued within 40 cycles", name);
  endtask

  int n, nb;
  bit s, b;
  int sat_stalls;
  bit held;

  initial begin
    errors = 0;
    checks = 0;
    c      = 0;
    m_known = 1'b0;
    m_stalls = 0;
    mc_avail = 0;
    for (int i = 0; i < 32; i++) begin
      avail[i] = 0;
      isld[i]  = 1'b0;
    end

    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("reset pc_write",     32'(hz.pc_write),     32'd1);
    chk("reset mc_busy",      32'(hz.mc_busy),      32'd0);
    chk("reset stall_cycles", 32'(hz.stall_cycles), 32'd0);

    // 1: lw x2 then add x3,x2,x4 -> exactly one stall
    drive(1, 1, 1, 0, 0, 2, 1, 1, 0, 0, 0);
    run_until_issue("t1 lw", n, nb);
    chk("t1 lw stalls", 32'(n), 32'd0);
    drive(1, 2, 1, 4, 1, 3, 1, 0, 0, 0, 0);
    run_until_issue("t1 add", n, nb);
    chk("t1 add stalls", 32'(n), 32'd1);
    chk("t1 stall_cycles", 32'(hz.stall_cycles), 32'd1);
    idle(2);

    // 2: store data from load (rs2) is exempt; store address (rs1) is not
    drive(1, 1, 1, 0, 0, 2, 1, 1, 0, 0, 0);
    run_until_issue("t2 lw a", n, nb);
    drive(1, 5, 1, 2, 1, 0, 0, 0, 1, 0, 0);
    run_until_issue("t2 sw data", n, nb);
    chk("t2 sw data stalls", 32'(n), 32'd0);
    idle(2);
    drive(1, 1, 1, 0, 0, 2, 1, 1, 0, 0, 0);
    run_until_issue("t2 lw b", n, nb);
    drive(1, 2, 1, 5, 1, 0, 0, 0, 1, 0, 0);
    run_until_issue("t2 sw addr", n, nb);
    chk("t2 sw addr stalls", 32'(n), 32'd1);
    idle(2);

    // 3: mul x6 then add x7,x6,x1 -> 4 stalls, mc_busy 4 cycles
    drive(1, 1, 1, 2, 1, 6, 1, 0, 0, 1, 0);
    run_until_issue("t3 mul", n, nb);
    drive(1, 6, 1, 1, 1, 7, 1, 0, 0, 0, 0);
    run_until_issue("t3 add", n, nb);
    chk("t3 add stalls", 32'(n), 32'd4);
    chk("t3 mc_busy cycles", 32'(nb), 32'd4);
    idle(6);

    // 4: structural, then WAW
    drive(1, 1, 1, 2, 1, 6, 1, 0, 0, 1, 0);
    run_until_issue("t4 mul a", n, nb);
    drive(1, 9, 1, 10, 1, 8, 1, 0, 0, 1, 0);
    run_until_issue("t4 div", n, nb);
    chk("t4 div struct stalls", 32'(n), 32'd4);
    idle(6);
    drive(1, 1, 1, 2, 1, 6, 1, 0, 0, 1, 0);
    run_until_issue("t4 mul b", n, nb);
    drive(1, 1, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    run_until_issue("t4 addi waw", n, nb);
    chk("t4 waw stalls", 32'(n), 32'd4);
    idle(6);

    // 5: flush beats stall and blocks issue
    drive(1, 1, 1, 0, 0, 2, 1, 1, 0, 0, 0);
    run_until_issue("t5 lw", n, nb);
    drive(1, 2, 1, 2, 1, 3, 1, 0, 0, 0, 1);
    step(s, b);
    chk("t5 flushed add stall", 32'(s), 32'd0);
    drive(1, 1, 1, 2, 1, 6, 1, 0, 0, 1, 1);
    step(s, b);
    idle(1);
    chk("t5 flushed mul mc_busy", 32'(b), 32'd0);
    idle(2);

    // 6: reset while mul pending
    drive(1, 1, 1, 2, 1, 6, 1, 0, 0, 1, 0);
    run_until_issue("t6 mul", n, nb);
    drive(1, 6, 1, 1, 1, 7, 1, 0, 0, 0, 0);
    rst = 1'b1;
    step(s, b);
    chk("t6 rst pc_write",      32'(hz.pc_write),      32'd0);
    chk("t6 rst control_stall", 32'(hz.control_stall), 32'd1);
    step(s, b);
    rst = 1'b0;
    run_until_issue("t6 add", n, nb);
    chk("t6 add stalls", 32'(n), 32'd0);
    chk("t6 stall_cycles", 32'(hz.stall_cycles), 32'd0);
    idle(2);

    // Random traffic over a small register window to provoke hazards
    held = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      int kind, rs1, rs2, rd;
      if (!(held && ($urandom_range(0, 1) == 1))) begin
        kind = $urandom_range(0, 5);
        rs1  = $urandom_range(0, 7);
        rs2  = $urandom_range(0, 7);
        rd   = $urandom_range(0, 7);
        case (kind)
          0: drive(1, rs1, 1, rs2, 1, rd, 1, 0, 0, 0, 0);
          1: drive(1, rs1, 1, rs2, 0, rd, 1, 1, 0, 0, 0);
          2: drive(1, rs1, 1, rs2, 1, rd, 0, 0, 1, 0, 0);
          3: drive(1, rs1, 1, rs2, 1, rd, 1, 0, 0, 1, 0);
          4: drive(1, rs1, 1, rs2, 0, rd, 1, 0, 0, 0, 0);
          default: drive(1, rs1, 1, rs2, 1, rd, 0, 0, 0, 0, 0);
        endcase
        hz.id_valid = ($urandom_range(0, 9) != 0);
      end
      hz.flush = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step(s, b);
      held = s && !rst;
    end
    rst = 1'b0;
    idle(6);

    // Saturation: a back-to-back stream of mul keeps the unit busy
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    drive(1, 1, 1, 2, 1, 6, 1, 0, 0, 1, 0);
    sat_stalls = 0;
    for (int i = 0; i < 90000 && sat_stalls < STALL_MAX + 4; i++) begin
      step(s, b);
      if (s) sat_stalls++;
    end
    chk("sat stall count reached", 32'(sat_stalls >= STALL_MAX + 4), 32'd1);
    chk("sat stall_cycles", 32'(hz.stall_cycles), 32'hFFFF);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
